// File: rtl/pipelined_csel_subtractor_pkg.sv
// pipelined_csel_subtractor_pkg: shared width default and overflow helper for the subtractor datapath
package pipelined_csel_subtractor_pkg;
  localparam int ARITH_WIDTH = 8;
  function automatic logic ovf_of(input logic am, input logic bm, input logic dm);
    return (am != bm) && (dm != am);
  endfunction
endpackage

// File: rtl/pipelined_csel_subtractor_csel_sub_block.sv
// csel_sub_block: combinational W-bit subtract a - b - bin as a + ~b + !bin, borrow = !carry
module csel_sub_block #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         bin,
  output logic [W-1:0] d,
  output logic         bout
);
  logic [W:0] s;
  assign s = {1'b0, a} + {1'b0, ~b} + {{W{1'b0}}, ~bin};
  assign d = s[W-1:0];
  assign bout = ~s[W];
endmodule

// File: rtl/pipelined_csel_subtractor.sv
// pipelined_csel_subtractor: two-stage carry-select a - b - bin with borrow, overflow and valid/ready
module pipelined_csel_subtractor
  import pipelined_csel_subtractor_pkg::*;
#(
  parameter int WIDTH = ARITH_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);
  localparam int HALF = WIDTH / 2;
  logic            s1_valid, s1_lb, s1_b0, s1_b1, s1_am, s1_bm;
  logic            lb, b0, b1, hb, s2_adv;
  logic [HALF-1:0] s1_lo, s1_h0, s1_h1, lo, h0, h1, hi;
  csel_sub_block #(.W(HALF)) u_lo (.a(a[HALF-1:0]), .b(b[HALF-1:0]), .bin(bin), .d(lo), .bout(lb));
  csel_sub_block #(.W(HALF)) u_h0 (.a(a[WIDTH-1:HALF]), .b(b[WIDTH-1:HALF]), .bin(1'b0), .d(h0), .bout(b0));
  csel_sub_block #(.W(HALF)) u_h1 (.a(a[WIDTH-1:HALF]), .b(b[WIDTH-1:HALF]), .bin(1'b1), .d(h1), .bout(b1));
  assign s2_adv = !out_valid || out_ready;
  assign in_ready = !s1_valid || s2_adv;
  // low-half borrow picks which precomputed high half is correct
  assign hi = s1_lb ? s1_h1 : s1_h0;
  assign hb = s1_lb ? s1_b1 : s1_b0;
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      out_valid <= 1'b0;
      diff      <= '0;
      bout      <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      if (in_ready) s1_valid <= in_valid;
      if (s2_adv) out_valid <= s1_valid;
      if (s1_valid && s2_adv) begin
        diff <= {hi, s1_lo};
        bout <= hb;
        ovf  <= ovf_of(s1_am, s1_bm, hi[HALF-1]);
      end
    end
  end
  always_ff @(posedge clk) begin
    if (in_valid && in_ready) begin
      s1_lo <= lo;
      s1_lb <= lb;
      s1_h0 <= h0;
      s1_h1 <= h1;
      s1_b0 <= b0;
      s1_b1 <= b1;
      s1_am <= a[WIDTH-1];
      s1_bm <= b[WIDTH-1];
    end
  end
endmodule

// File: tb/tb_pipelined_csel_subtractor.sv
// tb_pipelined_csel_subtractor: directed table, back-pressure, streaming and reset checks with a scoreboard
module tb_pipelined_csel_subtractor;
  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       bin;
    logic [7:0] diff;
    logic       bout;
    logic       ovf;
  } vec_t;

  logic       clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b0, bin = 1'b0;
  logic       in_ready, out_valid, bout, ovf;
  logic [7:0] a = '0, b = '0, diff;
  int         vec_cnt = 0, err_cnt = 0, stalls = 0;
  vec_t       exp_q[$];
  vec_t       tbl[13];

  pipelined_csel_subtractor #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .bin(bin),
    .out_valid(out_valid), .out_ready(out_ready), .diff(diff), .bout(bout), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic finish_now();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  endtask

  function automatic vec_t model(input logic [7:0] ma, input logic [7:0] mb, input logic mbin);
    vec_t v;
    int   d;
    d = int'(ma) - int'(mb) - int'(mbin);
    v.a = ma; v.b = mb; v.bin = mbin;
    v.diff = 8'(d);
    v.bout = d < 0;
    v.ovf = (ma[7] != mb[7]) && (v.diff[7] != ma[7]);
    return v;
  endfunction

  // offers one beat from posedge+1 and holds it until the handshake edge
  task automatic send(input vec_t v);
    int t;
    a = v.a; b = v.b; bin = v.bin; in_valid = 1'b1;
    t = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      t++;
      stalls++;
      if (t > 200) begin
        vec_cnt++; err_cnt++;
        $display("FAIL send_timeout: in_ready stuck at 0");
        finish_now();
      end
    end
    exp_q.push_back(v);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int t = 0; t < 200; t++) begin
      if (exp_q.size() == 0) return;
      @(posedge clk); #1;
    end
    vec_cnt++; err_cnt++;
    $display("FAIL drain_timeout: %0d results missing", exp_q.size());
    finish_now();
  endtask

  // output scoreboard: the head result must be presented, unchanged, until taken
  always @(negedge clk) begin
    if (rst) exp_q.delete();
    else if (out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        vec_cnt++; err_cnt++;
        $display("FAIL spurious_out: diff=%0h with no beat outstanding", diff);
      end else begin
        chk("diff", 32'(diff), 32'(exp_q[0].diff));
        chk("bout", 32'(bout), 32'(exp_q[0].bout));
        chk("ovf", 32'(ovf), 32'(exp_q[0].ovf));
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    tbl[0]  = '{8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0};
    tbl[1]  = '{8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0};
    tbl[2]  = '{8'h0A, 8'h04, 1'b1, 8'h05, 1'b0, 1'b0};
    tbl[3]  = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1};
    tbl[4]  = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0};
    tbl[5]  = '{8'h7F, 8'h80, 1'b0, 8'hFF, 1'b1, 1'b1};
    tbl[6]  = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
    tbl[7]  = '{8'h00, 8'hFF, 1'b0, 8'h01, 1'b1, 1'b0};
    tbl[8]  = '{8'h80, 8'h7F, 1'b1, 8'h00, 1'b0, 1'b1};
    tbl[9]  = '{8'hF0, 8'h0F, 1'b0, 8'hE1, 1'b0, 1'b0};
    tbl[10] = '{8'h10, 8'h01, 1'b0, 8'h0F, 1'b0, 1'b0};
    tbl[11] = '{8'h01, 8'h02, 1'b0, 8'hFF, 1'b1, 1'b0};
    tbl[12] = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1};

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_out_valid", 32'(out_valid), 0);
    chk("reset_diff", 32'(diff), 0);
    chk("reset_bout", 32'(bout), 0);
    chk("reset_ovf", 32'(ovf), 0);
    chk("reset_in_ready", 32'(in_ready), 1);
    @(posedge clk); #1;

    out_ready = 1'b1;
    send(tbl[0]);
    @(negedge clk);
    chk("latency_s1", 32'(out_valid), 0);
    @(negedge clk);
    chk("latency_s2", 32'(out_valid), 1);
    drain();

    for (int i = 0; i < 13; i++) send(tbl[i]);
    drain();

    out_ready = 1'b0;
    send(tbl[3]);
    send(tbl[5]);
    a = tbl[8].a; b = tbl[8].b; bin = tbl[8].bin; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("full_in_ready", 32'(in_ready), 0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("pop_push_in_ready", 32'(in_ready), 1);
    exp_q.push_back(tbl[8]);
    @(posedge clk); #1;
    in_valid = 1'b0;
    drain();

    stalls = 0;
    for (int i = 0; i < 16; i++)
      send(model(8'($urandom_range(255)), 8'($urandom_range(255)), 1'($urandom_range(1))));
    chk("stream_stalls", 32'(stalls), 0);
    drain();

    out_ready = 1'b0;
    send(tbl[1]);
    send(tbl[2]);
    rst = 1'b1;
    a = tbl[9].a; b = tbl[9].b; bin = tbl[9].bin; in_valid = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("midrst_out_valid", 32'(out_valid), 0);
    chk("midrst_diff", 32'(diff), 0);
    chk("midrst_bout", 32'(bout), 0);
    chk("midrst_ovf", 32'(ovf), 0);
    chk("midrst_in_ready", 32'(in_ready), 1);
    out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    send(tbl[12]);
    drain();

    finish_now();
  end
endmodule
